// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: parity modes, FSM states and the
// data_bits -> bit-count mapping.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    MARK = 2'd3
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // data_bits code 0..3 selects 5..8 data bits per frame
  function automatic logic [3:0] data_bits_to_n(input logic [1:0] data_bits);
    return 4'd5 + {2'b00, data_bits};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte buffer feeding the transmitter; count/full/empty come straight
// from the registered pointers, so in_ready has no path from push.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             pop_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              push_en, pop_en;

  // Extra pointer MSB distinguishes full from empty
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign full_o     = (count_o == DEPTH_L);
  assign empty_o    = (count_o == '0);
  assign push_en    = push_i && !full_o;
  assign pop_en     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with runtime frame format (5-8 data bits,
// none/even/odd/mark parity, 1/2 stop bits), paced by an external baud_tick.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          baud_tick,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DATA_W + 1);

  tx_state_e         state_q;
  parity_mode_e      par_mode_q;
  logic [DATA_W-1:0] shift_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [CW-1:0]     nbits_q;
  logic              two_stop_q;
  logic              stop_cnt_q;
  logic              par_acc_q;
  logic              tx_pin_q;
  logic              busy_q;
  logic              done_q;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              frame_end, start_frame, parity_bit;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (in_valid),
    .push_data_i (in_data),
    .pop_i       (start_frame),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign frame_end   = baud_tick && (state_q == ST_STOP) && (!two_stop_q || stop_cnt_q);
  // A new frame starts from IDLE or straight out of the final stop bit
  assign start_frame = !fifo_empty && ((baud_tick && (state_q == ST_IDLE)) || frame_end);

  always_comb begin
    parity_bit = 1'b1;
    case (par_mode_q)
      EVEN:    parity_bit = par_acc_q;
      ODD:     parity_bit = ~par_acc_q;
      default: parity_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      par_mode_q <= NONE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      par_acc_q  <= 1'b0;
      tx_pin_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (start_frame) begin
        shift_q    <= fifo_head;
        nbits_q    <= CW'(data_bits_to_n(data_bits));
        par_mode_q <= parity_mode_e'(parity_mode);
        two_stop_q <= two_stop;
        par_acc_q  <= 1'b0;
        tx_pin_q   <= 1'b0;
        busy_q     <= 1'b1;
        state_q    <= ST_START;
      end else if (baud_tick) begin
        case (state_q)
          ST_IDLE: ;
          ST_START: begin
            tx_pin_q  <= shift_q[0];
            par_acc_q <= shift_q[0];
            shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
            bit_cnt_q <= CW'(1);
            state_q   <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_cnt_q == nbits_q) begin
              if (par_mode_q == NONE) begin
                tx_pin_q   <= 1'b1;
                stop_cnt_q <= 1'b0;
                state_q    <= ST_STOP;
              end else begin
                tx_pin_q <= parity_bit;
                state_q  <= ST_PARITY;
              end
            end else begin
              tx_pin_q  <= shift_q[0];
              par_acc_q <= par_acc_q ^ shift_q[0];
              shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
          ST_PARITY: begin
            tx_pin_q   <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= ST_STOP;
          end
          ST_STOP: begin
            if (two_stop_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign in_ready = !fifo_full;
  assign tx_pin   = tx_pin_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed checks of uart_tx_cfg: frame formats, FIFO fill/drain, reset abort.
module tb_uart_tx_cfg;

  localparam int TICK = 55;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [1:0] data_bits = 2'd3;
  logic [1:0] parity_mode = 2'd0;
  logic       two_stop = 1'b0;
  logic       tx_pin, tx_busy, tx_done;
  logic [2:0] fifo_count;
  logic       tick_en = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  uart_tx_cfg #(.FIFO_DEPTH(4), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx_pin      (tx_pin),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    int div = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        if (div == TICK-1) begin
          baud_tick = 1'b1;
          div = 0;
        end else begin
          baud_tick = 1'b0;
          div++;
        end
      end else begin
        baud_tick = 1'b0;
        div = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // exp holds the expected line level of bit period i at position i
  task automatic frame(input string tag, input int nbits, input logic [15:0] exp,
                       input bit single, input bit b2b, input int exp_cnt);
    int waited = 0;
    int viol = 0;
    int busy_cyc = 0;
    int dones = 0;
    logic [15:0] got = '0;
    while (tx_pin !== 1'b0 && waited < 4*TICK) begin
      @(negedge clk);
      waited++;
    end
    if (tx_pin !== 1'b0) begin
      chk({tag, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (b2b) chk({tag, "_gap"}, waited, 0);
    if (exp_cnt >= 0) chk({tag, "_count"}, fifo_count, exp_cnt);
    for (int c = 0; c <= nbits*TICK; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 1 && tx_done) dones++;
      if (c < nbits*TICK) begin
        if (tx_pin !== exp[c/TICK]) viol++;
        if (c % TICK == TICK/2) got[c/TICK] = tx_pin;
        if (tx_busy) busy_cyc++;
      end
    end
    chk({tag, "_bits"}, got, exp & ((16'd1 << nbits) - 16'd1));
    chk({tag, "_hold"}, viol, 0);
    chk({tag, "_done"}, dones, 1);
    if (single) begin
      chk({tag, "_busy_len"}, busy_cyc, nbits*TICK);
      chk({tag, "_busy_end"}, tx_busy, 1'b0);
    end
  endtask

  initial begin
    int dones;
    int lows;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx_pin", tx_pin, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // 8N1, 0x55
    tick_en = 1'b1;
    data_bits = 2'd3; parity_mode = 2'd0; two_stop = 1'b0;
    push(8'h55);
    frame("8n1_55", 10, 16'b1010101010, 1'b1, 1'b0, 0);

    // 7E2, 0x41
    data_bits = 2'd2; parity_mode = 2'd1; two_stop = 1'b1;
    push(8'h41);
    frame("7e2_41", 11, 16'b11010000010, 1'b1, 1'b0, 0);

    // 8O1, 0x55: data XOR is 0, odd parity bit 1
    data_bits = 2'd3; parity_mode = 2'd2; two_stop = 1'b0;
    push(8'h55);
    frame("8o1_55", 11, 16'b11010101010, 1'b1, 1'b0, 0);

    // 5 data bits, mark parity, 0xFF
    data_bits = 2'd0; parity_mode = 2'd3; two_stop = 1'b0;
    push(8'hFF);
    frame("5m1_ff", 8, 16'b11111110, 1'b1, 1'b0, 0);

    // Fill with ticks stopped
    data_bits = 2'd3; parity_mode = 2'd0; two_stop = 1'b0;
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    push(8'h10); chk("fill_rdy1", in_ready, 1'b1);
    push(8'h11); chk("fill_rdy2", in_ready, 1'b1);
    push(8'h12); chk("fill_rdy3", in_ready, 1'b1);
    push(8'h13); chk("fill_rdy4", in_ready, 1'b0);
    chk("fill_count4", fifo_count, 3'd4);
    push(8'h14); chk("fill_rdy5", in_ready, 1'b0);
    chk("fill_count5", fifo_count, 3'd4);

    // Drain back-to-back
    tick_en = 1'b1;
    frame("q_10", 10, 16'b1000100000, 1'b0, 1'b0, 3);
    frame("q_11", 10, 16'b1000100010, 1'b0, 1'b1, 2);
    frame("q_12", 10, 16'b1000100100, 1'b0, 1'b1, 1);
    frame("q_13", 10, 16'b1000100110, 1'b1, 1'b1, 0);
    repeat (2*TICK) @(negedge clk);
    chk("q_no_fifth_busy", tx_busy, 1'b0);
    chk("q_no_fifth_pin", tx_pin, 1'b1);

    // Reset in the middle of a DATA bit of 0xA5
    push(8'hA5);
    lows = 0;
    while (tx_pin !== 1'b0 && lows < 4*TICK) begin
      @(negedge clk);
      lows++;
    end
    chk("abort_started", tx_pin, 1'b0);
    repeat (TICK + 10) @(negedge clk);
    push(8'h33);
    chk("abort_pre_busy", tx_busy, 1'b1);
    chk("abort_pre_count", fifo_count, 3'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_tx_pin", tx_pin, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    chk("abort_count", fifo_count, 3'd0);
    chk("abort_in_ready", in_ready, 1'b1);
    dones = 0;
    lows = 0;
    for (int c = 0; c < 3*TICK; c++) begin
      @(negedge clk);
      if (tx_done) dones++;
      if (tx_pin !== 1'b1) lows++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_line_idle", lows, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, buffered UART transmitter. It serialises bytes from an internal FIFO onto `tx_pin`, paced by an external one-cycle `baud_tick` strobe. Frame format is selectable at runtime: 5–8 data bits, none/even/odd/mark parity, and 1 or 2 stop bits. It sits between the host-side byte producer and the pad, and shares the same baud-tick source as the receiver.

## Interface
- `FIFO_DEPTH`, 4, number of buffered bytes; power of two, ≥ 2.
- `DATA_W`, 8, width of `in_data`; the maximum data bits per frame.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high; clears FIFO, FSM and outputs.
- `baud_tick` in 1: one-`clk` strobe, once per bit period.
- `in_valid` in 1: producer offers `in_data`.
- `in_data` in `DATA_W`: byte to send; bits above `data_bits` are ignored.
- `in_ready` out 1: `!full`; a push occurs when `in_valid && in_ready`.
- `data_bits` in 2: 0→5, 1→6, 2→7, 3→8 data bits.
- `parity_mode` in 2: 0 none, 1 even, 2 odd, 3 mark (parity bit = 1).
- `two_stop` in 1: 0 → one stop bit, 1 → two stop bits.
- `tx_pin` out 1: serial line; idles high.
- `tx_busy` out 1: high while a frame is on the line (FSM ≠ IDLE).
- `tx_done` out 1: one-cycle pulse at the end of the last stop bit.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: bytes currently buffered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- All FSM transitions happen only on cycles where `baud_tick=1`.
- IDLE → START on tick when FIFO is non-empty:
  - pop the head byte;
  - latch the byte plus `data_bits`, `parity_mode` and `two_stop` into frame registers;
  - drive `tx_pin=0`.
- Config inputs may change at any time. The new values affect only frames that start afterwards.
- START → DATA on tick. DATA shifts bits out LSB first, one per tick, for N = `data_bits`+5 bits.
- After the last data bit:
  - parity_mode ≠ 0 → PARITY;
  - parity_mode = 0 → STOP.
- Parity bit value:
  - even: XOR of the N data bits;
  - odd: inverted XOR;
  - mark: 1.
- STOP drives 1 for 1 or 2 bit periods.
- On the tick ending the final stop bit:
  - pulse `tx_done` for one cycle;
  - if FIFO is non-empty, pop and go directly to START (no idle gap);
  - otherwise go to IDLE.
- FIFO:
  - circular buffer with read/write pointers;
  - simultaneous push and pop leaves the count unchanged;
  - push is blocked when full;
  - pop never occurs when empty.
- A push on the same cycle as an IDLE tick with an empty FIFO is not popped until the next tick.

## Timing
- Reset values:
  - `tx_pin=1`, `tx_busy=0`, `tx_done=0`;
  - `fifo_count=0`, `in_ready=1`;
  - FSM in IDLE, pointers at 0.
- Reset mid-frame aborts the frame. `tx_pin` is 1 the cycle after reset is sampled, and the FIFO contents are discarded.
- `tx_pin` is registered. It changes on the clock edge at which the tick is sampled and is stable for a whole bit period.
- Latency: first start-bit edge = first tick after the byte is written into the FIFO.
- `tx_busy` rises together with the start bit. It falls on the same edge as the `tx_done` pulse, unless a back-to-back frame follows.
- Frame length = 1 + N + (parity ? 1 : 0) + (two_stop ? 2 : 1) bit periods.
- `in_ready` and `fifo_count` are registered-state derived and reflect the current pointers. `in_ready` has no combinational path from `in_valid`.

## Structure
- Package `uart_pkg` holds:
  - `parity_mode_e` (NONE, EVEN, ODD, MARK);
  - `tx_state_e`;
  - the `data_bits` → N mapping function.
- Sub-module `uart_tx_fifo` (parametrised by `FIFO_DEPTH`, `DATA_W`) provides push/pop, full/empty and count.
- Top level contains the FSM, bit counter, shift register and parity accumulator.

## Test plan
- 8N1, tick every 55 clk, push 0x55:
  - `tx_pin` = 0,1,0,1,0,1,0,1,0,1, each held 55 clk;
  - one `tx_done` pulse;
  - `tx_busy` high for exactly 10 bit periods.
- 7E2, push 0x41:
  - line = 0, 1000001 (LSB first), parity 0, stop 1,1;
  - total 11 bit periods.
- 8O1, push 0x55 → parity bit 1.
- Mark, 5 data bits, push 0xFF → 0, 11111, 1, 1.
- `baud_tick` held 0, push 5 bytes (0x10..0x14):
  - `in_ready` low after the 4th push;
  - `fifo_count`=4;
  - 5th byte not accepted.
- Enable ticks with the same 4 bytes queued:
  - frames are back-to-back with no idle period between the stop bit and the next start bit;
  - 4 `tx_done` pulses;
  - `fifo_count` decrements on each start.
- Assert `reset` during a DATA bit of 0xA5:
  - `tx_pin`=1 next cycle, `tx_busy`=0, `fifo_count`=0;
  - no `tx_done` pulse.
